n_clic_arbiter: RTL and testbench

- Interrupt arbiter and nesting scheduler for the N-CLIC core.
- Latches edge-triggered interrupt sources and selects the highest-priority enabled pending source whose priority exceeds the current level.
- Presents the winner to the core's interrupt-entry sequencer with a req/ack handshake.
- Tracks nested preemption with a level stack that is pushed on entry and popped on interrupt return (mret).

---
 rtl/n_clic_arbiter.sv | 174 +++++++++++++++++
 tb/tb_n_clic_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n_clic_arbiter.sv
// N-CLIC interrupt arbiter: latches source edges, picks the best enabled pending
// source above the current level, hands it to the core and tracks nesting levels.
module n_clic_arbiter #(
    parameter int unsigned VecSize    = 8,
    parameter int unsigned PrioWidth  = 3,
    parameter int unsigned StackDepth = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [VecSize-1:0]                irq_i,
    input  logic                              cfg_we,
    input  logic [$clog2(VecSize)-1:0]        cfg_idx,
    input  logic [PrioWidth-1:0]              cfg_prio,
    input  logic                              cfg_en,
    output logic                              take_req,
    output logic [$clog2(VecSize)-1:0]        take_id,
    output logic [PrioWidth-1:0]              take_level,
    input  logic                              take_ack,
    input  logic                              mret_i,
    output logic [PrioWidth-1:0]              level_o,
    output logic [$clog2(StackDepth+1)-1:0]   depth_o,
    output logic                              err_o
);

    localparam int unsigned IdxW   = $clog2(VecSize);
    localparam int unsigned DepthW = $clog2(StackDepth + 1);
    localparam int unsigned SpW    = (StackDepth > 1) ? $clog2(StackDepth) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [VecSize-1:0]   irq_q;
    logic [VecSize-1:0]   pend_q;
    logic [VecSize-1:0]   en_q;
    logic [VecSize-1:0]   irq_rise;
    logic [VecSize-1:0]   pend_clr;
    logic [PrioWidth-1:0] prio_q  [VecSize];
    logic [PrioWidth-1:0] stack_q [StackDepth];

    logic                 cand_found;
    logic                 cand_valid;
    logic [IdxW-1:0]      cand_id;
    logic [PrioWidth-1:0] cand_prio;

    logic                 req_d;
    logic [IdxW-1:0]      id_d;
    logic [PrioWidth-1:0] tlvl_d;
    logic [PrioWidth-1:0] level_d;
    logic [DepthW-1:0]    depth_d;
    logic                 err_d;
    logic                 push;
    logic [SpW-1:0]       push_idx;
    logic [PrioWidth-1:0] push_level;
    logic [PrioWidth-1:0] pop_level;

    assign irq_rise = irq_i & ~irq_q;

    // Highest priority wins; strict compare keeps the lowest index on a tie.
    always_comb begin
        cand_found = 1'b0;
        cand_id    = '0;
        cand_prio  = '0;
        for (int i = 0; i < VecSize; i++) begin
            if (pend_q[i] && en_q[i] && (prio_q[i] > level_o) &&
                (!cand_found || (prio_q[i] > cand_prio))) begin
                cand_found = 1'b1;
                cand_id    = IdxW'(i);
                cand_prio  = prio_q[i];
            end
        end
    end

    assign cand_valid = cand_found && (depth_o < DepthW'(StackDepth));
    assign pop_level  = stack_q[SpW'(depth_o - DepthW'(1))];

    // Next state: mret pop is resolved first so a same-cycle ack pushes the popped level.
    always_comb begin
        state_d    = state_q;
        req_d      = take_req;
        id_d       = take_id;
        tlvl_d     = take_level;
        level_d    = level_o;
        depth_d    = depth_o;
        err_d      = err_o;
        push       = 1'b0;
        push_idx   = '0;
        push_level = '0;
        pend_clr   = '0;

        if (mret_i) begin
            if (depth_o != '0) begin
                level_d = pop_level;
                depth_d = depth_o - DepthW'(1);
            end else begin
                level_d = '0;
                err_d   = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (cand_valid) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    id_d    = cand_id;
                    tlvl_d  = cand_prio;
                end
            end
            S_REQ: begin
                if (take_ack) begin
                    push              = 1'b1;
                    push_idx          = SpW'(depth_d);
                    push_level        = level_d;
                    level_d           = take_level;
                    depth_d           = depth_d + DepthW'(1);
                    pend_clr[take_id] = 1'b1;
                    req_d             = 1'b0;
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            take_req   <= 1'b0;
            take_id    <= '0;
            take_level <= '0;
            level_o    <= '0;
            depth_o    <= '0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            take_req   <= req_d;
            take_id    <= id_d;
            take_level <= tlvl_d;
            level_o    <= level_d;
            depth_o    <= depth_d;
            err_o      <= err_d;
        end
    end

    // Source state and level stack; a new edge beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q  <= '0;
            pend_q <= '0;
            en_q   <= '0;
            for (int i = 0; i < VecSize; i++) begin
                prio_q[i] <= '0;
            end
            for (int j = 0; j < StackDepth; j++) begin
                stack_q[j] <= '0;
            end
        end else begin
            irq_q  <= irq_i;
            pend_q <= (pend_q & ~pend_clr) | irq_rise;
            if (cfg_we) begin
                prio_q[cfg_idx] <= cfg_prio;
                en_q[cfg_idx]   <= cfg_en;
            end
            if (push) begin
                stack_q[push_idx] <= push_level;
            end
        end
    end

endmodule

// File: tb/tb_n_clic_arbiter.sv
// Directed bench for n_clic_arbiter: arbitration vector table plus nesting,
// hold, stack-full, underflow, simultaneous mret/ack and reset sequences.
module tb_n_clic_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] irq_i;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [2:0] cfg_prio;
    logic       cfg_en;
    logic       take_req;
    logic [2:0] take_id;
    logic [2:0] take_level;
    logic       take_ack;
    logic       mret_i;
    logic [2:0] level_o;
    logic [2:0] depth_o;
    logic       err_o;

    int n_cmp;
    int n_err;

    n_clic_arbiter #(.VecSize(8), .PrioWidth(3), .StackDepth(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_i      (irq_i),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_prio   (cfg_prio),
        .cfg_en     (cfg_en),
        .take_req   (take_req),
        .take_id    (take_id),
        .take_level (take_level),
        .take_ack   (take_ack),
        .mret_i     (mret_i),
        .level_o    (level_o),
        .depth_o    (depth_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      mask;
        logic [7:0]      en;
        logic [7:0][2:0] prios;
        logic            exp_req;
        logic [2:0]      exp_id;
        logic [2:0]      exp_lvl;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic cfg(input int idx, input logic [2:0] p, input logic e);
        cfg_we   = 1'b1;
        cfg_idx  = 3'(idx);
        cfg_prio = p;
        cfg_en   = e;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_i = m;
        tick();
        irq_i = 8'h00;
    endtask

    task automatic ack();
        take_ack = 1'b1;
        tick();
        take_ack = 1'b0;
    endtask

    task automatic mret();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
    endtask

    task automatic chk_req(input string name, input logic [2:0] id, input logic [2:0] lvl);
        chk({name, ".req"}, 32'(take_req), 32'd1);
        chk({name, ".id"}, 32'(take_id), 32'(id));
        chk({name, ".lvl"}, 32'(take_level), 32'(lvl));
    endtask

    task automatic chk_lvl(input string name, input logic [2:0] lvl, input logic [2:0] dep);
        chk({name, ".level"}, 32'(level_o), 32'(lvl));
        chk({name, ".depth"}, 32'(depth_o), 32'(dep));
    endtask

    initial begin
        vec_t v;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        irq_i = '0;
        cfg_we = 1'b0;
        cfg_idx = '0;
        cfg_prio = '0;
        cfg_en = 1'b0;
        take_ack = 1'b0;
        mret_i = 1'b0;

        for (int k = 0; k < 8; k++) vecs[k] = '0;
        vecs[0].mask = 8'h04; vecs[0].en = 8'h04; vecs[0].prios[2] = 3'd3;
        vecs[0].exp_req = 1'b1; vecs[0].exp_id = 3'd2; vecs[0].exp_lvl = 3'd3;
        vecs[1].mask = 8'h12; vecs[1].en = 8'h12; vecs[1].prios[1] = 3'd4; vecs[1].prios[4] = 3'd4;
        vecs[1].exp_req = 1'b1; vecs[1].exp_id = 3'd1; vecs[1].exp_lvl = 3'd4;
        vecs[2].mask = 8'h08; vecs[2].en = 8'h00; vecs[2].prios[3] = 3'd2;
        vecs[3].mask = 8'h01; vecs[3].en = 8'h01; vecs[3].prios[0] = 3'd0;
        vecs[4].mask = 8'hA1; vecs[4].en = 8'hA1; vecs[4].prios[0] = 3'd1;
        vecs[4].prios[7] = 3'd7; vecs[4].prios[5] = 3'd6;
        vecs[4].exp_req = 1'b1; vecs[4].exp_id = 3'd7; vecs[4].exp_lvl = 3'd7;
        vecs[5].mask = 8'h4C; vecs[5].en = 8'h4C; vecs[5].prios[2] = 3'd5;
        vecs[5].prios[3] = 3'd5; vecs[5].prios[6] = 3'd5;
        vecs[5].exp_req = 1'b1; vecs[5].exp_id = 3'd2; vecs[5].exp_lvl = 3'd5;
        vecs[6].mask = 8'h00; vecs[6].en = 8'hFF;
        for (int s = 0; s < 8; s++) vecs[6].prios[s] = 3'd7;
        vecs[7].mask = 8'hC1; vecs[7].en = 8'h7F; vecs[7].prios[7] = 3'd7;
        vecs[7].prios[6] = 3'd3; vecs[7].prios[0] = 3'd1;
        vecs[7].exp_req = 1'b1; vecs[7].exp_id = 3'd6; vecs[7].exp_lvl = 3'd3;

        // Reset state
        tick();
        tick();
        chk("rst.req", 32'(take_req), 32'd0);
        chk("rst.id", 32'(take_id), 32'd0);
        chk("rst.tlvl", 32'(take_level), 32'd0);
        chk_lvl("rst", 3'd0, 3'd0);
        chk("rst.err", 32'(err_o), 32'd0);
        reset = 1'b1;
        tick();

        // Arbitration table, each vector from a clean reset at level 0
        for (int k = 0; k < 8; k++) begin
            v = vecs[k];
            do_reset();
            for (int s = 0; s < 8; s++) cfg(s, v.prios[s], v.en[s]);
            pulse(v.mask);
            tick();
            chk($sformatf("vec%0d.req", k), 32'(take_req), 32'(v.exp_req));
            if (v.exp_req) begin
                chk($sformatf("vec%0d.id", k), 32'(take_id), 32'(v.exp_id));
                chk($sformatf("vec%0d.lvl", k), 32'(take_level), 32'(v.exp_lvl));
                ack();
                chk($sformatf("vec%0d.level", k), 32'(level_o), 32'(v.exp_lvl));
                chk($sformatf("vec%0d.depth", k), 32'(depth_o), 32'd1);
            end
        end

        // Entry latency and hold
        do_reset();
        cfg(2, 3'd3, 1'b1);
        pulse(8'h04);
        chk("entry.early", 32'(take_req), 32'd0);
        tick();
        chk_req("entry", 3'd2, 3'd3);
        tick();
        chk_req("entry.hold", 3'd2, 3'd3);
        ack();
        chk("entry.dropreq", 32'(take_req), 32'd0);
        chk_lvl("entry", 3'd3, 3'd1);

        // Nesting
        cfg(5, 3'd2, 1'b1);
        cfg(6, 3'd5, 1'b1);
        pulse(8'h20);
        tick();
        tick();
        chk("nest.lowprio", 32'(take_req), 32'd0);
        pulse(8'h40);
        tick();
        chk_req("nest.src6", 3'd6, 3'd5);
        ack();
        chk_lvl("nest.ack6", 3'd5, 3'd2);
        mret();
        chk_lvl("nest.mret1", 3'd3, 3'd1);
        chk("nest.mret1req", 32'(take_req), 32'd0);
        mret();
        chk_lvl("nest.mret2", 3'd0, 3'd0);
        tick();
        chk_req("nest.src5", 3'd5, 3'd2);
        ack();
        mret();
        chk_lvl("nest.done", 3'd0, 3'd0);
        chk("nest.err", 32'(err_o), 32'd0);

        // Tie and hold against a higher-priority arrival
        do_reset();
        cfg(1, 3'd4, 1'b1);
        cfg(4, 3'd4, 1'b1);
        cfg(7, 3'd7, 1'b1);
        pulse(8'h12);
        tick();
        chk_req("tie", 3'd1, 3'd4);
        pulse(8'h80);
        tick();
        chk_req("tie.hold", 3'd1, 3'd4);
        cfg(1, 3'd4, 1'b0);
        chk_req("tie.disabled", 3'd1, 3'd4);
        ack();
        chk_lvl("tie.ack", 3'd4, 3'd1);
        tick();
        chk_req("tie.src7", 3'd7, 3'd7);
        ack();
        mret();
        mret();
        tick();
        chk_req("tie.src4", 3'd4, 3'd4);

        // Stack full
        do_reset();
        for (int s = 0; s < 4; s++) cfg(s, 3'(s + 1), 1'b1);
        cfg(6, 3'd6, 1'b1);
        for (int s = 0; s < 4; s++) begin
            pulse(8'(1 << s));
            tick();
            chk_req($sformatf("full.take%0d", s), 3'(s), 3'(s + 1));
            ack();
        end
        chk_lvl("full", 3'd4, 3'd4);
        pulse(8'h40);
        tick();
        tick();
        tick();
        chk("full.noreq", 32'(take_req), 32'd0);
        mret();
        chk_lvl("full.mret", 3'd3, 3'd3);
        tick();
        chk_req("full.src6", 3'd6, 3'd6);

        // Underflow, then mret coinciding with ack
        do_reset();
        mret();
        chk("uflow.err", 32'(err_o), 32'd1);
        chk_lvl("uflow", 3'd0, 3'd0);
        tick();
        chk("uflow.sticky", 32'(err_o), 32'd1);
        cfg(2, 3'd3, 1'b1);
        cfg(5, 3'd6, 1'b1);
        pulse(8'h04);
        tick();
        ack();
        chk_lvl("sim.pre", 3'd3, 3'd1);
        pulse(8'h20);
        tick();
        chk_req("sim", 3'd5, 3'd6);
        take_ack = 1'b1;
        mret_i = 1'b1;
        tick();
        take_ack = 1'b0;
        mret_i = 1'b0;
        chk_lvl("sim.both", 3'd6, 3'd1);
        chk("sim.req", 32'(take_req), 32'd0);
        mret();
        chk_lvl("sim.after", 3'd0, 3'd0);
        chk("sim.err", 32'(err_o), 32'd1);

        // Asynchronous reset while requesting
        cfg(3, 3'd5, 1'b1);
        pulse(8'h08);
        tick();
        chk("rreq.pre", 32'(take_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rreq.req", 32'(take_req), 32'd0);
        chk("rreq.id", 32'(take_id), 32'd0);
        chk("rreq.tlvl", 32'(take_level), 32'd0);
        chk("rreq.err", 32'(err_o), 32'd0);
        chk_lvl("rreq", 3'd0, 3'd0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("rreq.quiet%0d", c), 32'(take_req), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
